// File: rtl/granule_scheduler.sv
// Back-end decode sequencer: walks gr0/gr1 x ch0/ch1 through requantizer,
// joint-stereo and IMDCT, with overrun, timeout and abort handling.
module granule_scheduler #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000
) (
    input  logic clk,
    input  logic rst,
    input  logic si_valid_in,
    input  logic mono,
    input  logic ms_en,
    input  logic huff_done,
    input  logic req_done,
    input  logic ms_done,
    input  logic imdct_done,
    output logic req_start,
    output logic ms_start,
    output logic imdct_start,
    output logic gr,
    output logic ch,
    output logic busy,
    output logic frame_done,
    output logic err_overrun,
    output logic err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HUFF,
        REQ,
        STEREO,
        IMDCT,
        DONE
    } state_t;

    state_t state, state_d;

    logic        mono_q, ms_en_q, pend;
    logic        mono_d, ms_en_d, pend_d;
    logic [19:0] wcnt, wcnt_d;
    logic        gr_d, ch_d, busy_d;
    logic        req_start_d, ms_start_d, imdct_start_d;
    logic        frame_done_d, err_overrun_d, err_timeout_d;
    logic        enter, to_huff, abandon;
    logic        more_ch, tmo, pend_zone;

    assign more_ch   = ~ch & ~mono_q;
    assign tmo       = (wcnt == TIMEOUT_CYCLES - 20'd1);
    assign pend_zone = (state != IDLE) && (state != WAIT_HUFF);

    always_comb begin
        state_d       = state;
        mono_d        = mono_q;
        ms_en_d       = ms_en_q;
        pend_d        = pend;
        gr_d          = gr;
        ch_d          = ch;
        busy_d        = busy;
        req_start_d   = 1'b0;
        ms_start_d    = 1'b0;
        imdct_start_d = 1'b0;
        frame_done_d  = 1'b0;
        err_overrun_d = 1'b0;
        err_timeout_d = 1'b0;
        enter         = 1'b0;
        to_huff       = 1'b0;
        abandon       = 1'b0;

        // Early Huffman completions are remembered one deep
        if (huff_done && pend_zone) begin
            err_overrun_d = pend;
            pend_d        = 1'b1;
        end

        unique case (state)
            IDLE: ;
            WAIT_HUFF: begin
                if (huff_done || pend) begin
                    pend_d      = 1'b0;
                    state_d     = REQ;
                    req_start_d = 1'b1;
                    enter       = 1'b1;
                end else if (tmo) begin
                    abandon = 1'b1;
                end
            end
            REQ: begin
                if (req_done) begin
                    if (more_ch) begin
                        ch_d    = 1'b1;
                        to_huff = 1'b1;
                    end else if (!mono_q && ms_en_q) begin
                        state_d    = STEREO;
                        ms_start_d = 1'b1;
                        enter      = 1'b1;
                    end else begin
                        ch_d          = 1'b0;
                        state_d       = IMDCT;
                        imdct_start_d = 1'b1;
                        enter         = 1'b1;
                    end
                end else if (tmo) begin
                    abandon = 1'b1;
                end
            end
            STEREO: begin
                if (ms_done) begin
                    ch_d          = 1'b0;
                    state_d       = IMDCT;
                    imdct_start_d = 1'b1;
                    enter         = 1'b1;
                end else if (tmo) begin
                    abandon = 1'b1;
                end
            end
            IMDCT: begin
                if (imdct_done) begin
                    if (more_ch) begin
                        ch_d          = 1'b1;
                        imdct_start_d = 1'b1;
                        enter         = 1'b1;
                    end else if (!gr) begin
                        gr_d    = 1'b1;
                        ch_d    = 1'b0;
                        to_huff = 1'b1;
                    end else begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                        enter        = 1'b1;
                    end
                end else if (tmo) begin
                    abandon = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                gr_d    = 1'b0;
                ch_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A pending completion skips the idle WAIT_HUFF cycle
        if (to_huff) begin
            enter = 1'b1;
            if (pend) begin
                state_d       = REQ;
                req_start_d   = 1'b1;
                pend_d        = huff_done;
                err_overrun_d = 1'b0;
            end else begin
                state_d = WAIT_HUFF;
            end
        end

        if (abandon) begin
            state_d       = IDLE;
            busy_d        = 1'b0;
            gr_d          = 1'b0;
            ch_d          = 1'b0;
            pend_d        = 1'b0;
            err_timeout_d = 1'b1;
        end

        // New side info always (re)starts a frame, silently
        if (si_valid_in) begin
            state_d       = WAIT_HUFF;
            mono_d        = mono;
            ms_en_d       = ms_en;
            gr_d          = 1'b0;
            ch_d          = 1'b0;
            busy_d        = 1'b1;
            pend_d        = 1'b0;
            req_start_d   = 1'b0;
            ms_start_d    = 1'b0;
            imdct_start_d = 1'b0;
            frame_done_d  = 1'b0;
            err_overrun_d = 1'b0;
            err_timeout_d = 1'b0;
            enter         = 1'b1;
        end

        if (enter || state_d == IDLE) begin
            wcnt_d = '0;
        end else begin
            wcnt_d = wcnt + 20'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mono_q      <= 1'b0;
            ms_en_q     <= 1'b0;
            pend        <= 1'b0;
            wcnt        <= '0;
            gr          <= 1'b0;
            ch          <= 1'b0;
            busy        <= 1'b0;
            req_start   <= 1'b0;
            ms_start    <= 1'b0;
            imdct_start <= 1'b0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            mono_q      <= mono_d;
            ms_en_q     <= ms_en_d;
            pend        <= pend_d;
            wcnt        <= wcnt_d;
            gr          <= gr_d;
            ch          <= ch_d;
            busy        <= busy_d;
            req_start   <= req_start_d;
            ms_start    <= ms_start_d;
            imdct_start <= imdct_start_d;
            frame_done  <= frame_done_d;
            err_overrun <= err_overrun_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule
